// File: rtl/topk_sorter.sv
// topk_sorter: streaming insertion sorter keeping the K largest (id, value) pairs of a pass.
// Optional macro TOPK_TIE_LOWID_EN: equal values rank by lower node ID instead of arrival order.
// Revision: 1.0
`default_nettype none

module topk_sorter #(
  parameter int M     = 64,
  parameter int WIDTH = 16,
  parameter int K     = 10,
  parameter int IDW   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDW-1:0]     in_id,
  input  logic [WIDTH-1:0]   in_val,
  input  logic               in_last,
  output logic [K*WIDTH-1:0] top_vals,
  output logic [K*IDW-1:0]   top_ids,
  output logic [K-1:0]       top_valid,
  output logic [6:0]         count,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [6:0] C_M    = 7'(M);
  localparam logic [6:0] C_LAST = 7'(M - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [6:0]       r_count;
  logic [WIDTH-1:0] r_val [K];
  logic [IDW-1:0]   r_id  [K];
  logic [K-1:0]     r_vld;

  logic             w_accept;
  logic             w_term;
  logic [K-1:0]     w_ins;
  logic [K-1:0]     w_above;
  logic [WIDTH-1:0] w_src_val [K];
  logic [IDW-1:0]   w_src_id  [K];

  // start wins over a coincident entry, so the entry is never counted
  assign w_accept = in_valid & in_ready & ~start;
  assign w_term   = w_accept & (in_last | (r_count == C_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_IDLE;
        S_COLLECT: if (w_term) w_next = S_DONE;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_count <= '0;
    else if (start)                        r_count <= '0;
    else if (w_accept && (r_count != C_M)) r_count <= r_count + 7'd1;
  end

  // The list stays sorted, so w_ins is a thermometer: every slot at or below
  // the insert point is set, and a slot whose upper neighbour is also set shifts down.
  for (genvar k = 0; k < K; k++) begin : g_slot
`ifdef TOPK_TIE_LOWID_EN
    assign w_ins[k] = ~r_vld[k] | (in_val > r_val[k]) |
                      ((in_val == r_val[k]) & (in_id < r_id[k]));
`else
    assign w_ins[k] = ~r_vld[k] | (in_val > r_val[k]);
`endif
    if (k == 0) begin : g_head
      assign w_above[k]   = 1'b0;
      assign w_src_val[k] = in_val;
      assign w_src_id[k]  = in_id;
    end else begin : g_body
      assign w_above[k]   = w_ins[k-1];
      assign w_src_val[k] = w_above[k] ? r_val[k-1] : in_val;
      assign w_src_id[k]  = w_above[k] ? r_id[k-1]  : in_id;
    end
    assign top_vals[k*WIDTH +: WIDTH] = r_val[k];
    assign top_ids[k*IDW +: IDW]      = r_id[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < K; k++) begin
        r_val[k] <= '0;
        r_id[k]  <= '0;
      end
      r_vld <= '0;
    end else if (start) begin
      for (int k = 0; k < K; k++) begin
        r_val[k] <= '0;
        r_id[k]  <= '0;
      end
      r_vld <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < K; k++) begin
        if (w_ins[k]) begin
          r_val[k] <= w_src_val[k];
          r_id[k]  <= w_src_id[k];
          r_vld[k] <= w_above[k] ? r_vld[k-1 < 0 ? 0 : k-1] : 1'b1;
        end
      end
    end
  end

  assign top_valid = r_vld;
  assign count     = r_count;

endmodule

`default_nettype wire

// File: doc/topk_sorter.md
Name: topk_sorter

Overview:
- Downstream stage of the pageRank top level.
- Consumes the final per-node PageRank values streamed out of the four ants (id, value pairs), keeps a running sorted list of the K largest, and presents them as packed top-K value and ID vectors.
- Implements the "sort" step: insertion into a K-deep register list, one element per cycle, all comparators working in parallel.

Parameters:
- M, 64, total number of nodes; a pass auto-terminates after M accepted entries.
- WIDTH, 16, node value width (unsigned).
- K, 10, list depth (number of top entries kept).
- IDW, 6, node ID width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; clears the list and begins a new pass.
- in_valid  input  1  an input entry is presented.
- in_ready  output  1  block accepts an entry this cycle.
- in_id  input  IDW  node ID of the entry.
- in_val  input  WIDTH  node value of the entry.
- in_last  input  1  marks the final entry of the pass.
- top_vals  output  K*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH]; slot 0 is the largest.
- top_ids  output  K*IDW  slot k occupies bits [k*IDW +: IDW].
- top_valid  output  K  slot k holds a real entry.
- count  output  7  number of entries accepted this pass (saturates at M).
- busy  output  1  pass in progress (COLLECT state).
- done  output  1  list is final; held high until the next start.

Behaviour:
- Reset (async): state IDLE; all slot values, IDs and top_valid cleared to 0; count=0; busy=0; done=0; in_ready=0.
- States:
  - IDLE: in_ready=0. start -> COLLECT.
  - COLLECT: in_ready=1, busy=1.
  - DONE: in_ready=0, done=1. start -> COLLECT.
- start in any state: clears all slots, top_valid and count on that edge; next state is COLLECT. start has priority over a simultaneous in_valid, which is ignored (not accepted).
- Accept: in_valid & in_ready at a rising edge. The list is updated on that same edge; outputs reflect the new entry the next cycle. Latency is 1 cycle, and sustained throughput is 1 entry per cycle.
- Insertion, evaluated in parallel for every slot k:
  - ins_k = !top_valid[k] | (in_val > val[k]), strictly greater than.
  - The insert position p is the lowest k with ins_k set.
  - Slots k>p take slot k-1. Slot p takes the new entry. Slot K-1's old content is dropped.
  - If no ins_k is set, the list is unchanged, but the entry is still counted.
- Ties: without the optional feature, the earlier-arriving entry ranks higher. The new entry goes below existing equal values.
- count increments per accepted entry.
- COLLECT -> DONE on the accepting edge when in_last=1, or when count reaches M. done rises the cycle after that edge.
- Fewer than K entries: unused slots keep value 0, ID 0, top_valid=0.
- Entries with value 0 are valid and occupy slots. top_valid distinguishes them from empty slots.
- Reset mid-pass: immediate clear to the reset state. The partial list is discarded.
- All outputs are registered; no combinational path from inputs to outputs except in_ready (which is state-derived only).

Optional Feature:
- Macro: TOPK_TIE_LOWID_EN.
- Defined: on equal values, the lower node ID ranks higher regardless of arrival order. The insert condition becomes (in_val > val[k]) | (in_val == val[k] & in_id < id[k]).
- Undefined: arrival-order tiebreak as above. No ID comparators are synthesized.

Test Plan:
- Reset then start; stream ids 0..63 with value = id*3, in_last on id 63 -> done=1; top_ids = 63..54 slot 0..9; top_vals = 189..162; count=64; top_valid=10'h3FF.
- Stream 4 entries (id5=100, id2=300, id9=200, id1=50) with in_last on the 4th -> slots 0..3 ids 2,9,5,1; slots 4..9 top_valid=0 and zero.
- Equal values: id7=500 then id3=500 -> without macro slot0=id7, slot1=id3; with TOPK_TIE_LOWID_EN slot0=id3, slot1=id7.
- No in_last, 64 entries all value 1 -> auto DONE after the 64th accept; slots hold the first 10 ids 0..9 (without macro); a 65th in_valid is not accepted (in_ready=0).
- Assert reset after 20 entries mid-pass -> all outputs zero immediately (asynchronously); start plus a new stream gives a correct fresh result.
- start pulsed in DONE with a simultaneous in_valid -> list cleared, entry not accepted, count=0, busy=1 next cycle.
